// File: rtl/recip_divider_pkg.sv
// recip_divider_pkg: FSM encoding, table limit and reciprocal numerator shared by the divider and its table
package recip_divider_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MULT, S_REM, S_FIX, S_DONE} state_t;
  localparam int LUT_M_MAX = 169;
  localparam logic [15:0] NUMER = 16'hFFFF;
  function automatic int msb_idx(input logic [31:0] v);
    int k;
    k = 0;
    for (int i = 0; i < 32; i++) if (v[i]) k = i;
    return k;
  endfunction
endpackage

// File: rtl/recip_divider_lut.sv
// divisions_lut: floor((2^16-1)/m) for 1..M_MAX, 0 for unsupported divisors
module divisions_lut
  import recip_divider_pkg::*;
#(
  parameter int M_W   = 9,
  parameter int M_MAX = LUT_M_MAX
) (
  input  logic [M_W-1:0] m,
  output logic [15:0]    recip
);
  localparam int AW = $clog2(M_MAX + 1);
  logic [15:0] rom [0:M_MAX];
  for (genvar i = 0; i <= M_MAX; i++) begin : g_rom
    assign rom[i] = (i == 0) ? 16'd0 : 16'(NUMER / i);
  end
  assign recip = (m > M_W'(M_MAX)) ? 16'd0 : rom[AW'(m)];
endmodule

// File: rtl/recip_divider.sv
// recip_divider: multi-cycle N/M via reciprocal multiply plus correction; DIV_POW2_BYPASS_EN shortcuts power-of-two divisors
module recip_divider
  import recip_divider_pkg::*;
#(
  parameter int N_W   = 16,
  parameter int M_W   = 9,
  parameter int M_MAX = LUT_M_MAX
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] N,
  input  logic [M_W-1:0] M,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [M_W-1:0] remainder,
  output logic           err
);
  localparam int RW = N_W + 1;
  state_t state;
  logic [N_W-1:0] nr, q;
  logic [M_W-1:0] mr;
  logic [15:0] recip, lut_recip;
  logic [RW-1:0] r;
  logic [1:0] fix_n;
  logic bad, pow2;
  divisions_lut #(.M_W(M_W), .M_MAX(M_MAX)) u_lut (.m(mr), .recip(lut_recip));
  assign bad = (mr == '0) || (mr > M_W'(M_MAX));
`ifdef DIV_POW2_BYPASS_EN
  assign pow2 = !bad && ((mr & (mr - 1'b1)) == '0);
`else
  assign pow2 = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      nr        <= '0;
      mr        <= '0;
      recip     <= '0;
      q         <= '0;
      r         <= '0;
      fix_n     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          nr    <= N;
          mr    <= M;
          busy  <= 1'b1;
          state <= S_LOOKUP;
        end
        S_LOOKUP: if (bad) begin
          err       <= 1'b1;
          quotient  <= '0;
          remainder <= '0;
          done      <= 1'b1;
          state     <= S_DONE;
        end else if (pow2) begin
          err       <= 1'b0;
          quotient  <= nr >> msb_idx(32'(mr));
          remainder <= M_W'(nr) & (mr - 1'b1);
          done      <= 1'b1;
          state     <= S_DONE;
        end else begin
          recip <= lut_recip;
          state <= S_MULT;
        end
        S_MULT: begin
          q     <= N_W'(({16'd0, nr} * {{N_W{1'b0}}, recip}) >> 16);
          fix_n <= '0;
          state <= S_REM;
        end
        S_REM: begin
          r     <= {1'b0, nr} - RW'({{M_W{1'b0}}, q} * {{N_W{1'b0}}, mr});
          state <= S_FIX;
        end
        // reciprocal underestimates, so at most three +1 corrections are ever needed
        S_FIX: if (r >= RW'(mr) && fix_n != 2'd3) begin
          q     <= q + 1'b1;
          r     <= r - RW'(mr);
          fix_n <= fix_n + 1'b1;
        end else begin
          quotient  <= q;
          remainder <= M_W'(r);
          err       <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_recip_divider.sv
// tb_recip_divider: randomized scoreboard bench for recip_divider against a floor/mod model
module tb_recip_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] n_in = '0;
  logic [8:0] m_in = '0;
  logic busy, done, err;
  logic [15:0] quotient;
  logic [8:0] remainder;
  int cyc = 0, compared = 0, mismatched = 0;
  bit go = 1'b0;
  typedef struct {logic [15:0] q; logic [8:0] r; logic e; int st; int lo; int hi;} exp_t;
  exp_t sb[$];
  logic [25:0] hold = '0;

  recip_divider dut (.clk(clk), .rst(rst), .start(start), .N(n_in), .M(m_in), .busy(busy),
                     .done(done), .quotient(quotient), .remainder(remainder), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int n, input int m, input int st);
    exp_t x;
    x.e = (m == 0 || m > 169);
    x.q = x.e ? 16'd0 : 16'(n / m);
    x.r = x.e ? 9'd0 : 9'(n % m);
    x.st = st;
    x.lo = x.e ? 2 : 5;
    x.hi = x.e ? 2 : 8;
`ifdef DIV_POW2_BYPASS_EN
    if (!x.e && (m & (m - 1)) == 0) begin x.lo = 2; x.hi = 2; end
`endif
    return x;
  endfunction

  task automatic issue(input int n, input int m);
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("idle_timeout", 32'(t), 0);
    start = 1'b1;
    n_in = 16'(n);
    m_in = 9'(m);
    sb.push_back(model(n, m, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    wait (go);
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_done: got done=1 required no pending operation (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("err", 32'(err), 32'(e.e));
          compared++;
          if (cyc - e.st < e.lo || cyc - e.st > e.hi) begin
            mismatched++;
            $display("FAIL latency: got %0d required %0d..%0d", cyc - e.st, e.lo, e.hi);
          end
          hold = {e.q, e.r, e.e};
        end
      end else if (busy === 1'b0) chk("hold", {6'd0, quotient, remainder, err}, {6'd0, hold});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    go = 1'b1;
    issue(1000, 7);
    issue(65535, 1);
    issue(65535, 169);
    issue(0, 100);
    issue(1000, 0);
    issue(1000, 170);
    issue(1000, 8);
    issue(65535, 511);
    issue(65535, 128);
    // a second start while busy must be ignored
    issue(5000, 13);
    chk("busy_after_start", 32'(busy), 1);
    @(negedge clk);
    start = 1'b1; n_in = 16'd1; m_in = 9'd3;
    @(negedge clk);
    start = 1'b0;
    // start during the DONE cycle must be ignored
    issue(77, 0);
    @(negedge clk);
    start = 1'b1; n_in = 16'd9; m_in = 9'd3;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 0);
    // reset while in FIX discards the operation
    issue(65535, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    hold = '0;
    @(negedge clk);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_quotient", 32'(quotient), 0);
    chk("midrst_remainder", 32'(remainder), 0);
    chk("midrst_err", 32'(err), 0);
    rst = 1'b0;
    issue(65535, 1);
    for (int i = 0; i < 300; i++) begin
      int m;
      m = (i % 12 == 0) ? ((i % 24 == 0) ? 0 : int'($urandom_range(170, 511))) : int'($urandom_range(1, 169));
      issue((i % 10 == 3) ? 65535 : int'($urandom_range(0, 65535)), m);
    end
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/recip_divider.md
RECIP_DIVIDER -- requirements
Module: recip_divider

Interface
- REQ-001 SHALL have parameter N_W, default 16: dividend, quotient and reciprocal width.
- REQ-002 SHALL have parameter M_W, default 9: divisor and remainder width.
- REQ-003 SHALL have parameter M_MAX, default 169: largest divisor the reciprocal table supports.
- REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
- REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-006 SHALL have port start, input, 1: request pulse that samples N and M.
- REQ-007 SHALL have port N, input, N_W: dividend.
- REQ-008 SHALL have port M, input, M_W: divisor.
- REQ-009 SHALL have port busy, output, 1: high from the cycle after an accepted start through the DONE cycle.
- REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
- REQ-011 SHALL have port quotient, output, N_W: floor(N/M).
- REQ-012 SHALL have port remainder, output, M_W: N mod M.
- REQ-013 SHALL have port err, output, 1: divisor out of range (M==0 or M>M_MAX).

Function
- REQ-014 SHALL accept start only in IDLE, registering N and M; start SHALL be ignored while busy.
- REQ-015 SHALL implement the FSM IDLE->LOOKUP->MULT->REM->FIX->DONE->IDLE.
- REQ-016 In LOOKUP, SHALL register recip = floor((2^16-1)/M) from the table; an invalid M SHALL instead go directly to DONE with err=1, quotient=0 and remainder=0.
- REQ-017 In MULT, SHALL register q = (N*recip)>>16 using a full 32-bit product.
- REQ-018 In REM, SHALL register r = N - q*M in at least N_W+1 bits.
- REQ-019 In FIX, while r>=M SHALL apply q=q+1 and r=r-M once per cycle; when r<M SHALL go to DONE.
- REQ-020 SHALL limit FIX to at most 3 increment cycles, so valid-path latency from start to done is 5 to 8 cycles.
- REQ-021 In DONE, SHALL pulse done for exactly one cycle, drive quotient/remainder/err from the result, and return to IDLE.
- REQ-022 SHALL hold quotient, remainder and err stable from DONE until the next accepted start.
- REQ-023 SHALL treat start asserted in the DONE cycle as ignored; start is accepted from the following IDLE cycle.
- REQ-024 SHALL require no wrap-around: the quotient never exceeds 2^N_W-1, and an intermediate q+1 overflow is impossible for valid M.

Reset
- REQ-025 On rst=1 at a clock edge, SHALL enter IDLE with busy=0, done=0, err=0, quotient=0 and remainder=0.
- REQ-026 rst SHALL override any in-progress operation, which is discarded with no done pulse.
- REQ-027 rst SHALL take priority over a simultaneous start.

Configuration
- REQ-028 Macro DIV_POW2_BYPASS_EN, when defined, SHALL make a valid power-of-two M (1,2,4,...,128) skip LOOKUP/MULT/REM/FIX.
- REQ-029 With DIV_POW2_BYPASS_EN defined, the bypass path SHALL compute quotient = N>>log2(M) and remainder = N & (M-1), and SHALL reach DONE on the cycle after start (done 2 cycles after start).
- REQ-030 Without DIV_POW2_BYPASS_EN, all divisors SHALL take the reciprocal path with identical results; only latency differs.

Structure
- REQ-031 A shared package SHALL hold the FSM state encoding, M_MAX, and the 2^16-1 numerator constant.
- REQ-032 The reciprocal table SHALL be instantiated as sub-module divisions_lut (M in, 16-bit reciprocal out, 0 for unsupported M).
- REQ-033 The divider SHALL contain no other sub-module; multiplies SHALL be inferred.

Verification
- REQ-034 N=1000, M=7 -> quotient=142, remainder=6, err=0, done 5-8 cycles after start.
- REQ-035 N=65535, M=1 with bypass off -> recip=65535, q after MULT=65534, one FIX cycle, final quotient=65535, remainder=0.
- REQ-036 N=65535, M=169 -> quotient=387, remainder=132; N=0, M=100 -> quotient=0, remainder=0.
- REQ-037 M=0 and M=170 -> err=1, quotient=0, remainder=0, done 2 cycles after start.
- REQ-038 rst asserted during FIX -> no done pulse, all outputs 0 next cycle, and a new start then completes correctly; start pulsed while busy -> ignored, first result unchanged.
- REQ-039 With DIV_POW2_BYPASS_EN: N=1000, M=8 -> quotient=125, remainder=0, done 2 cycles after start.
- REQ-040 Random sweep over M=1..169 and all N against a floor/mod model, in both macro builds.
